// File: rtl/sc_types_pkg.sv
// Shared types, default constants and ramp helpers for the charge actuator.
// The welded-contact check is built only when SC_ACT_WELD_DETECT_EN is defined.
package sc_types_pkg;

  typedef enum logic [2:0] {
    IDLE, CLOSE, RAMP_UP, CHARGE, RAMP_DN, OPEN, FAULT
  } act_state_t;

  typedef enum logic [3:0] {
    FLT_NONE      = 4'd0,
    FLT_CLOSE_TMO = 4'd1,
    FLT_OPEN_TMO  = 4'd2,
    FLT_BAT_LOST  = 4'd3,
    FLT_WELD      = 4'd4
  } act_fault_t;

  localparam int DEF_RELAY_TMO  = 20;
  localparam int DEF_RAMP_DIV   = 4;
  localparam int DEF_RAMP_STEP  = 8;
  localparam int DEF_I_MAX      = 64;
  localparam int DEF_DEB_CYCLES = 8;
  localparam int DEF_V_FULL     = 3500;
  localparam int DEF_V_HYST     = 100;
  localparam int DEF_FULL_DWELL = 16;

  // The sum is formed one bit wider so a large step saturates instead of wrapping.
  function automatic logic [7:0] ramp_up_step(input logic [7:0] cur,
                                              input logic [7:0] step,
                                              input logic [7:0] ceil);
    logic [8:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum >= {1'b0, ceil}) ? ceil : sum[7:0];
  endfunction

  function automatic logic [7:0] ramp_dn_step(input logic [7:0] cur,
                                              input logic [7:0] step);
    return (cur <= step) ? 8'd0 : cur - step;
  endfunction

endpackage

// File: rtl/sc_debounce.sv
// Consecutive-sample filter: the output follows the input only after it has
// differed from the output for N back-to-back clock cycles.
module sc_debounce #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic q
);

  localparam int              CW   = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (raw == q) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      q   <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sc_charge_actuator.sv
// Relay sequencing, current soft-ramp and battery status for the charging FSM.
// Optional welded-contact detection in IDLE: define SC_ACT_WELD_DETECT_EN.
module sc_charge_actuator
  import sc_types_pkg::*;
#(
  parameter int RELAY_TMO  = DEF_RELAY_TMO,
  parameter int RAMP_DIV   = DEF_RAMP_DIV,
  parameter int RAMP_STEP  = DEF_RAMP_STEP,
  parameter int I_MAX      = DEF_I_MAX,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int V_FULL     = DEF_V_FULL,
  parameter int V_HYST     = DEF_V_HYST,
  parameter int FULL_DWELL = DEF_FULL_DWELL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        charge_enable,
  input  logic        relay_active,
  input  logic        relay_fb,
  input  logic        bat_present_raw,
  input  logic [11:0] bat_voltage,
  output logic        relay_coil,
  output logic [7:0]  current_ref,
  output logic        battery_connected,
  output logic        battery_full,
  output logic        act_fault,
  output logic [3:0]  act_fault_code
);

  localparam logic [7:0]  TMO_L   = 8'(RELAY_TMO);
  localparam logic [7:0]  DIV_L   = 8'(RAMP_DIV - 1);
  localparam logic [7:0]  STEP_L  = 8'(RAMP_STEP);
  localparam logic [7:0]  IMAX_L  = 8'(I_MAX);
  localparam logic [7:0]  DWELL_L = 8'(FULL_DWELL - 1);
  localparam logic [11:0] V_SET_L = 12'(V_FULL);
  localparam logic [11:0] V_CLR_L = 12'(V_FULL - V_HYST);

  act_state_t state;
  act_fault_t fault_code;
  logic [7:0] timer, timer_nxt, full_cnt, up_ref, dn_ref;
  logic       go, tmo, step_due, weld_tmo;

  sc_debounce #(.N(DEB_CYCLES)) u_presence (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bat_present_raw),
    .q       (battery_connected)
  );

  assign go             = charge_enable & relay_active & battery_connected & ~battery_full;
  assign timer_nxt      = timer + 8'd1;
  assign tmo            = (timer_nxt == TMO_L);
  assign step_due       = (timer == DIV_L);
  assign up_ref         = ramp_up_step(current_ref, STEP_L, IMAX_L);
  assign dn_ref         = ramp_dn_step(current_ref, STEP_L);
  assign act_fault_code = fault_code;

`ifdef SC_ACT_WELD_DETECT_EN
  assign weld_tmo = relay_fb & tmo;
`else
  assign weld_tmo = 1'b0;
`endif

  // Full is only accumulated while actually charging; hysteresis or loss clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_cnt     <= '0;
      battery_full <= 1'b0;
    end else begin
      if (state == CHARGE && bat_voltage >= V_SET_L)
        full_cnt <= (full_cnt > DWELL_L) ? full_cnt : full_cnt + 8'd1;
      else
        full_cnt <= '0;
      if (!battery_connected || bat_voltage < V_CLR_L)
        battery_full <= 1'b0;
      else if (state == CHARGE && bat_voltage >= V_SET_L && full_cnt == DWELL_L)
        battery_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      relay_coil  <= 1'b0;
      current_ref <= '0;
      act_fault   <= 1'b0;
      fault_code  <= FLT_NONE;
    end else begin
      timer <= timer_nxt;
      case (state)
        IDLE: begin
          relay_coil  <= 1'b0;
          current_ref <= '0;
          if (weld_tmo) begin
            state      <= FAULT;
            act_fault  <= 1'b1;
            fault_code <= FLT_WELD;
          end else if (go) begin
            state      <= CLOSE;
            relay_coil <= 1'b1;
            timer      <= '0;
          end else if (!relay_fb) begin
            timer <= '0;
          end
        end
        CLOSE: begin
          if (relay_fb && go) begin
            state <= RAMP_UP;
            timer <= '0;
          end else if (tmo) begin
            state      <= FAULT;
            relay_coil <= 1'b0;
            act_fault  <= 1'b1;
            fault_code <= FLT_CLOSE_TMO;
          end else if (!go) begin
            state      <= OPEN;
            relay_coil <= 1'b0;
            timer      <= '0;
          end
        end
        RAMP_UP, CHARGE, RAMP_DN: begin
          // Battery loss cuts power at once; no ramp-down is attempted.
          if (!battery_connected) begin
            state       <= FAULT;
            relay_coil  <= 1'b0;
            current_ref <= '0;
            act_fault   <= 1'b1;
            fault_code  <= FLT_BAT_LOST;
          end else if (state != RAMP_DN && !go) begin
            state <= RAMP_DN;
            timer <= '0;
          end else if (state == RAMP_UP && step_due) begin
            current_ref <= up_ref;
            timer       <= '0;
            if (up_ref == IMAX_L) state <= CHARGE;
          end else if (state == RAMP_DN && current_ref == '0) begin
            state      <= OPEN;
            relay_coil <= 1'b0;
            timer      <= '0;
          end else if (state == RAMP_DN && step_due) begin
            current_ref <= dn_ref;
            timer       <= '0;
            if (dn_ref == '0) begin
              state      <= OPEN;
              relay_coil <= 1'b0;
            end
          end
        end
        OPEN: begin
          if (!relay_fb) begin
            state <= IDLE;
            timer <= '0;
          end else if (tmo) begin
            state      <= FAULT;
            act_fault  <= 1'b1;
            fault_code <= FLT_OPEN_TMO;
          end
        end
        FAULT: begin
          relay_coil  <= 1'b0;
          current_ref <= '0;
          if (!charge_enable && !relay_fb) begin
            state      <= IDLE;
            act_fault  <= 1'b0;
            fault_code <= FLT_NONE;
            timer      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_charge_actuator.sv
// Directed bench for sc_charge_actuator with a queue scoreboard of ramp values.
// Honours SC_ACT_WELD_DETECT_EN the same way the design does.
module tb_sc_charge_actuator;
  import sc_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        charge_enable, relay_active, relay_fb, bat_present_raw;
  logic [11:0] bat_voltage;
  logic        relay_coil, battery_connected, battery_full, act_fault;
  logic [7:0]  current_ref;
  logic [3:0]  act_fault_code;

  int n_checks = 0;
  int n_pass   = 0;
  int fb_mode  = 0;  // 0: contacts follow coil after 3 cycles, 1: stuck open, 2: stuck closed
  int exp_q[$];

  always #5 clk = ~clk;

  sc_charge_actuator dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .charge_enable     (charge_enable),
    .relay_active      (relay_active),
    .relay_fb          (relay_fb),
    .bat_present_raw   (bat_present_raw),
    .bat_voltage       (bat_voltage),
    .relay_coil        (relay_coil),
    .current_ref       (current_ref),
    .battery_connected (battery_connected),
    .battery_full      (battery_full),
    .act_fault         (act_fault),
    .act_fault_code    (act_fault_code)
  );

  // Relay plant: auxiliary contact model driven on the falling edge.
  initial begin
    logic [2:0] pipe;
    pipe     = '0;
    relay_fb = 1'b0;
    forever begin
      @(negedge clk);
      pipe = {pipe[1:0], relay_coil};
      case (fb_mode)
        1:       relay_fb = 1'b0;
        2:       relay_fb = 1'b1;
        default: relay_fb = pipe[2];
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ref_change(input logic [7:0] prev, input int budget, output int cycles);
    cycles = 0;
    while (current_ref === prev && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic cycles_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   cyc;
    int   exp_v;
    logic [7:0] prev;

    reset_n = 1'b0; charge_enable = 1'b0; relay_active = 1'b0;
    bat_present_raw = 1'b0; bat_voltage = 12'd3000;
    #12;
    check("reset_outputs", {relay_coil, current_ref, battery_connected, battery_full,
                            act_fault, act_fault_code}, 0);
    check("reset_state", dut.state, IDLE);
    @(negedge clk); reset_n = 1'b1;

    // Presence debounce: exactly 8 cycles.
    bat_present_raw = 1'b1;
    cycles_n(7);
    check("deb_7", battery_connected, 0);
    cycles_n(1);
    check("deb_8", battery_connected, 1);

    // Start: coil closes, current ramps 8..64 every 4 cycles.
    charge_enable = 1'b1; relay_active = 1'b1;
    for (int v = 8; v <= 64; v += 8) exp_q.push_back(v);
    for (int i = 0; i < 10 && relay_coil !== 1'b1; i++) @(negedge clk);
    check("coil_on", relay_coil, 1);
    prev = current_ref;
    for (int k = 0; k < 8; k++) begin
      wait_ref_change(prev, 12, cyc);
      exp_v = exp_q.pop_front();
      check("ramp_up", current_ref, exp_v);
      if (k > 0) check("ramp_up_period", cyc, 4);
      prev = current_ref;
    end
    @(negedge clk);
    check("state_charge", dut.state, CHARGE);
    check("charge_ref", current_ref, 64);

    // Full: 16 cycles at V_FULL, then ramp down and open.
    bat_voltage = 12'd3500;
    cycles_n(15);
    check("full_15", battery_full, 0);
    cycles_n(1);
    check("full_16", battery_full, 1);
    for (int v = 56; v >= 0; v -= 8) exp_q.push_back(v);
    prev = current_ref;
    for (int k = 0; k < 8; k++) begin
      wait_ref_change(prev, 12, cyc);
      exp_v = exp_q.pop_front();
      check("ramp_dn", current_ref, exp_v);
      if (k > 0) check("ramp_dn_period", cyc, 4);
      prev = current_ref;
    end
    check("coil_off_at_zero", relay_coil, 0);
    charge_enable = 1'b0;
    for (int i = 0; i < 20 && dut.state !== IDLE; i++) @(negedge clk);
    check("back_to_idle", dut.state, IDLE);
    bat_voltage = 12'd3450;
    cycles_n(3);
    check("full_hyst_hold", battery_full, 1);
    bat_voltage = 12'd3390;
    cycles_n(1);
    check("full_clear", battery_full, 0);

    // Relay never closes: close timeout after 20 cycles.
    fb_mode = 1;
    charge_enable = 1'b1;
    for (int i = 0; i < 10 && relay_coil !== 1'b1; i++) @(negedge clk);
    check("close_coil_on", relay_coil, 1);
    cyc = 0;
    while (act_fault !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("close_tmo_cycles", cyc, 20);
    check("close_tmo_code", act_fault_code, FLT_CLOSE_TMO);
    check("close_tmo_coil", relay_coil, 0);
    charge_enable = 1'b0;
    cycles_n(1);
    check("close_fault_clear", {act_fault, act_fault_code}, 0);
    check("close_fault_idle", dut.state, IDLE);

    // Battery pulled while charging.
    fb_mode = 0;
    charge_enable = 1'b1;
    for (int i = 0; i < 80 && dut.state !== CHARGE; i++) @(negedge clk);
    check("pull_in_charge", dut.state, CHARGE);
    bat_present_raw = 1'b0;
    cycles_n(8);
    check("pull_deb", battery_connected, 0);
    check("pull_ref_held", current_ref, 64);
    cycles_n(1);
    check("pull_fault", act_fault, 1);
    check("pull_code", act_fault_code, FLT_BAT_LOST);
    check("pull_ref_zero", current_ref, 0);
    check("pull_coil", relay_coil, 0);
    charge_enable = 1'b0;
    for (int i = 0; i < 20 && act_fault !== 1'b0; i++) @(negedge clk);
    check("pull_fault_exit", {act_fault, act_fault_code}, 0);

    // Glitch rejection: 7 low samples do not drop presence.
    bat_present_raw = 1'b1;
    cycles_n(8);
    check("reconnect", battery_connected, 1);
    bat_present_raw = 1'b0;
    cycles_n(7);
    bat_present_raw = 1'b1;
    cycles_n(10);
    check("glitch_reject", battery_connected, 1);

    // Asynchronous reset mid-ramp.
    charge_enable = 1'b1;
    for (int i = 0; i < 40 && current_ref !== 8'd16; i++) @(negedge clk);
    check("midramp_ref", current_ref, 16);
    reset_n = 1'b0;
    #1;
    check("async_reset", {relay_coil, current_ref, battery_connected, battery_full,
                          act_fault, act_fault_code}, 0);
    charge_enable = 1'b0;
    fb_mode = 2;
    cycles_n(5);
    reset_n = 1'b1;

    // Contacts closed while idle.
`ifdef SC_ACT_WELD_DETECT_EN
    cycles_n(19);
    check("weld_19", act_fault, 0);
    cycles_n(1);
    check("weld_fault", act_fault, 1);
    check("weld_code", act_fault_code, FLT_WELD);
    cycles_n(5);
    check("weld_exit_blocked", act_fault, 1);
    fb_mode = 1;
    for (int i = 0; i < 5 && act_fault !== 1'b0; i++) @(negedge clk);
    check("weld_exit", {act_fault, act_fault_code}, 0);
`else
    cycles_n(30);
    check("no_weld_fault", {act_fault, act_fault_code}, 0);
    check("no_weld_idle", dut.state, IDLE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
